// File: rtl/iir_pkg.sv
// Shared constants for the multi-channel biquad: coefficient map, FSM encoding
// and accumulator sizing.
package iir_pkg;

  localparam logic [2:0] CoefB0 = 3'd0;
  localparam logic [2:0] CoefB1 = 3'd1;
  localparam logic [2:0] CoefB2 = 3'd2;
  localparam logic [2:0] CoefA1 = 3'd3;
  localparam logic [2:0] CoefA2 = 3'd4;

  // The MAC step index doubles as the coefficient address; the last step is a2.
  localparam logic [2:0] MacLast = CoefA2;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } state_e;

  function automatic int unsigned acc_width(input int unsigned wl, input int unsigned cw);
    return wl + cw + 3;
  endfunction

endpackage

// File: rtl/iir_sat_round.sv
// Round-half-up, arithmetic shift by FRAC, then saturate (SAT=1) or wrap (SAT=0)
// the accumulator down to a WL-bit sample.
module iir_sat_round #(
  parameter int unsigned AW   = 35,
  parameter int unsigned WL   = 16,
  parameter int unsigned FRAC = 14,
  parameter int unsigned SAT  = 1
) (
  input  logic signed [AW-1:0] acc,
  output logic signed [WL-1:0] res
);

  localparam logic signed [AW:0] Half = {{AW{1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [AW:0] MaxV = {{(AW - WL + 2){1'b0}}, {(WL - 1){1'b1}}};
  localparam logic signed [AW:0] MinV = -MaxV - 1;

  logic signed [AW:0] sum;
  logic signed [AW:0] shifted;

  // One guard bit so the rounding add cannot overflow.
  assign sum     = $signed({acc[AW-1], acc}) + Half;
  assign shifted = sum >>> FRAC;

  always_comb begin
    res = shifted[WL-1:0];
    if (SAT != 0) begin
      if (shifted > MaxV) begin
        res = MaxV[WL-1:0];
      end else if (shifted < MinV) begin
        res = MinV[WL-1:0];
      end
    end
  end

endmodule

// File: rtl/iir_mc_biquad.sv
// Multi-channel direct-form-I biquad sharing one multiplier; each accepted
// sample takes 5 MAC cycles plus one output cycle.
module iir_mc_biquad
  import iir_pkg::*;
#(
  parameter int unsigned WL   = 16,
  parameter int unsigned CW   = 16,
  parameter int unsigned FRAC = 14,
  parameter int unsigned NCH  = 4,
  parameter int unsigned SAT  = 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NCH)-1:0]   in_ch,
  input  logic signed [WL-1:0]     din_x,
  input  logic                     coef_we,
  input  logic [2:0]               coef_addr,
  input  logic signed [CW-1:0]     coef_data,
  output logic                     out_valid,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic signed [WL-1:0]     data_out
);

  localparam int unsigned CHW = $clog2(NCH);
  localparam int unsigned AW  = acc_width(WL, CW);
  localparam int unsigned PW  = WL + CW;

  state_e                state_q;
  logic [2:0]            mac_cnt_q;
  logic [CHW-1:0]        ch_q;
  logic signed [WL-1:0]  x_q;
  logic signed [AW-1:0]  acc_q;
  logic signed [CW-1:0]  b0_q, b1_q, b2_q, a1_q, a2_q;
  logic signed [WL-1:0]  x1_q [NCH];
  logic signed [WL-1:0]  x2_q [NCH];
  logic signed [WL-1:0]  y1_q [NCH];
  logic signed [WL-1:0]  y2_q [NCH];
  logic                  out_valid_q;
  logic [CHW-1:0]        out_ch_q;
  logic signed [WL-1:0]  data_out_q;

  logic signed [CW-1:0]  coef_sel;
  logic signed [WL-1:0]  data_sel;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  prod_ext;
  logic signed [WL-1:0]  y_new;

  always_comb begin
    coef_sel = b0_q;
    data_sel = x_q;
    unique case (mac_cnt_q)
      CoefB0: begin coef_sel = b0_q; data_sel = x_q;        end
      CoefB1: begin coef_sel = b1_q; data_sel = x1_q[ch_q]; end
      CoefB2: begin coef_sel = b2_q; data_sel = x2_q[ch_q]; end
      CoefA1: begin coef_sel = a1_q; data_sel = y1_q[ch_q]; end
      default: begin coef_sel = a2_q; data_sel = y2_q[ch_q]; end
    endcase
    prod     = PW'(coef_sel) * PW'(data_sel);
    prod_ext = AW'(prod);
  end

  iir_sat_round #(
    .AW   (AW),
    .WL   (WL),
    .FRAC (FRAC),
    .SAT  (SAT)
  ) u_sat_round (
    .acc (acc_q),
    .res (y_new)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      mac_cnt_q   <= '0;
      ch_q        <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      data_out_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      if (coef_we && state_q == StIdle) begin
        case (coef_addr)
          CoefB0:  b0_q <= coef_data;
          CoefB1:  b1_q <= coef_data;
          CoefB2:  b2_q <= coef_data;
          CoefA1:  a1_q <= coef_data;
          CoefA2:  a2_q <= coef_data;
          default: ;
        endcase
      end
      if (enable) begin
        unique case (state_q)
          StIdle: begin
            // Out-of-range channels are accepted and silently discarded.
            if (in_valid && 32'(in_ch) < NCH) begin
              state_q   <= StMac;
              x_q       <= din_x;
              ch_q      <= in_ch;
              acc_q     <= '0;
              mac_cnt_q <= '0;
            end
          end
          StMac: begin
            acc_q     <= (mac_cnt_q >= CoefA1) ? acc_q - prod_ext : acc_q + prod_ext;
            mac_cnt_q <= mac_cnt_q + 3'd1;
            if (mac_cnt_q == MacLast) begin
              state_q <= StOut;
            end
          end
          StOut: begin
            out_valid_q   <= 1'b1;
            out_ch_q      <= ch_q;
            data_out_q    <= y_new;
            x2_q[ch_q]    <= x1_q[ch_q];
            x1_q[ch_q]    <= x_q;
            y2_q[ch_q]    <= y1_q[ch_q];
            y1_q[ch_q]    <= y_new;
            state_q       <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign in_ready  = nrst && enable && (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign data_out  = data_out_q;

endmodule

// File: doc/iir_mc_biquad.md
IIR_MC_BIQUAD -- requirements
Module: iir_mc_biquad

Interface
REQ-001 Parameters SHALL be: WL, default 16, signed sample width; CW, default 16, signed coefficient width, Q(CW-FRAC).FRAC; FRAC, default 14, coefficient fraction bits; NCH, default 4, channel count (>=2); SAT, default 1, 1=saturate output, 0=wrap.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be:
 clk  in  1  clock, rising edge.
 nrst  in  1  async active-low reset.
 enable  in  1  run enable.
 in_valid  in  1  input sample valid.
 in_ready  out  1  block can accept a sample.
 in_ch  in  $clog2(NCH)  channel of input sample.
 din_x  in  WL  signed input sample.
 coef_we  in  1  coefficient write strobe.
 coef_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 reserved.
 coef_data  in  CW  signed coefficient.
 out_valid  out  1  one-cycle output strobe.
 out_ch  out  $clog2(NCH)  channel of data_out.
 data_out  out  WL  signed filtered sample.

Function
REQ-004 Each channel SHALL compute a direct-form-I biquad: y[n] = (b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]) >> FRAC.
REQ-005 All channels SHALL share one coefficient set; each channel SHALL keep private state x1, x2, y1, y2 (WL bits each).
REQ-006 One shared multiplier SHALL be time-multiplexed; FSM states: IDLE, MAC, OUT.
REQ-007 IDLE: in_ready=enable; handshake (in_valid & in_ready) at edge T SHALL latch din_x and in_ch and go to MAC.
REQ-008 MAC SHALL last exactly 5 cycles, one product per cycle, in order b0, b1, b2, a1, a2; then OUT.
REQ-009 OUT (1 cycle): out_valid=1; data_out and out_ch valid; channel state updated (x2<=x1, x1<=x, y2<=y1, y1<=y); next state IDLE.
REQ-010 Latency: out_valid SHALL assert on cycle T+6; throughput SHALL be one sample per 7 cycles; no output back-pressure.
REQ-011 Accumulator width SHALL be WL+CW+3 bits, signed, cleared on entering MAC.
REQ-012 Result SHALL be rounded: add 2^(FRAC-1), then arithmetic shift right by FRAC.
REQ-013 SAT=1: clamp to [-2^(WL-1), 2^(WL-1)-1]; SAT=0: keep the low WL bits. The stored y1 SHALL equal data_out.
REQ-014 in_ready SHALL be 0 in MAC and OUT; in_valid there SHALL be ignored.
REQ-015 Coefficient writes SHALL take effect only in IDLE; a coef_we outside IDLE, or to addresses 5-7, SHALL be dropped.
REQ-016 enable=0: FSM SHALL hold its current state, in_ready=0, out_valid=0; channel state and coefficients SHALL be preserved.
REQ-017 in_ch >= NCH on handshake: sample SHALL be consumed; no output and no state change.

Reset
REQ-018 nrst=0 SHALL asynchronously force: FSM=IDLE, all coefficients=0, all channel state=0, accumulator=0, out_valid=0, data_out=0, out_ch=0, in_ready=0.
REQ-019 Reset during MAC or OUT SHALL abort the sample with no output; the first handshake after release SHALL behave as from power-up.

Structure
REQ-020 Package iir_pkg SHALL hold the coefficient address constants, FSM state encoding, and the accumulator width function.
REQ-021 Channel state SHALL live in register arrays indexed by channel; the single sub-module iir_sat_round SHALL perform round/shift/saturate.

Verification
REQ-022 Passthrough: b0=16384, others 0; ch0 x=1234 -> data_out=1234, out_valid exactly 6 cycles after handshake.
REQ-023 Pole: b0=16384, a1=-8192; ch1 impulse 1000 then zeros -> 1000, 500, 250, 125.
REQ-024 Channel isolation: same pole set; impulse 1000 on ch2, 0 interleaved on ch3 -> ch3 outputs all 0; ch2 decays as in REQ-023.
REQ-025 Saturation: b0=32767, x=30000 -> SAT=1 gives 32767; SAT=0 gives the wrapped low 16 bits of the rounded result.
REQ-026 Hazards: coef_we to b0 during MAC is dropped (output unchanged); nrst pulse mid-MAC -> no out_valid, all state zero; enable low mid-MAC stretches latency by the low cycles and gives the same result.
